// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 byte mux.
// Grants one requester at a time and caps each grant at MAX_BURST beats over valid/ready.
module mux4_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        REQ,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] C,
    input  logic [DATA_W-1:0] D,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT,
    output logic              OUT_VALID,
    output logic [3:0]        GNT,
    output logic [1:0]        SEL
);

    // state | meaning
    // IDLE  | no grant outstanding, waiting for any REQ
    // BUSY  | SEL owns the channel, beats metered by CNT
    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [3:0]        sel_onehot;
    logic [3:0]        others;
    logic [DATA_W-1:0] data_sel;
    logic              busy;
    logic              beat;
    logic              rel_drop;
    logic              rel_burst;

    // First set bit of r, searching from p upward with wraparound.
    function automatic logic [1:0] arb(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        arb = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) arb = idx;
        end
    endfunction

    always_comb begin
        data_sel = A;
        case (sel_q)
            2'd0: data_sel = A;
            2'd1: data_sel = B;
            2'd2: data_sel = C;
            2'd3: data_sel = D;
            default: data_sel = A;
        endcase
    end

    assign busy       = (state_q == ST_BUSY);
    assign sel_onehot = 4'b0001 << sel_q;
    assign GNT        = busy ? sel_onehot : 4'b0000;
    assign OUT_VALID  = busy & REQ[sel_q];
    assign OUT        = OUT_VALID ? data_sel : '0;
    assign SEL        = sel_q;

    assign beat      = OUT_VALID & OUT_READY;
    assign rel_drop  = busy & ~REQ[sel_q];
    assign rel_burst = beat & (cnt_q == LAST_BEAT);
    assign others    = REQ & ~sel_onehot;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ != 4'b0000) begin
                    sel_d   = arb(REQ, ptr_q);
                    cnt_d   = 4'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rel_drop || rel_burst) begin
                    ptr_d = sel_q + 2'd1;
                    cnt_d = 4'd0;
                    // Hand over with no dead cycle when anyone else is waiting.
                    if (others != 4'b0000) begin
                        sel_d = arb(others, sel_q + 2'd1);
                    end else if (!rel_burst) begin
                        state_d = ST_IDLE;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
